core_run_ctrl: RTL and testbench

Synthesisable run controller that drives the pipeline core's reset and bounds each execution run. It replaces fixed reset delays and fixed run lengths with parameters, and adds halt detection, retire counting and timeout reporting. It sits between the top-level clock/reset and pipeline_top. It can be reused by benches and by FPGA self-test wrappers.

---
 rtl/core_run_ctrl.sv | 133 +++++++++++++
 tb/tb_core_run_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
// core_run_ctrl -- run controller for the pipeline core.
//
// This block drives the core's reset and bounds each execution run. A start
// pulse holds the core in reset and then releases it. The run ends when the
// core halts or when the cycle budget is used up. The block counts RUN
// cycles and retired instructions for every run.
//
// Parameters:
//   RST_CYCLES  reset-hold length per run (1..255)
//   MAX_CYCLES  RUN-state cycle budget before timeout (>= 1)
//   CNT_W       width of the reported counters
//
// Ports:
//   clk, rst      clock (rising edge) and synchronous active-high reset
//   start         run request pulse; honoured in IDLE and DONE only
//   halt_in       core halted; sampled in RUN only
//   retire_valid  core retired one instruction; sampled in RUN only
//   core_rst_n    active-low reset to the core
//   busy / done   run in progress (RESET or RUN) / run finished
//   timeout       the run ended because the budget was used up
//   cycle_count   RUN cycles in the current or last run (saturating)
//   instr_count   retired instructions in the current or last run (saturating)
//   stall_count   RUN cycles with no retire (saturating)
//
// Optional feature: define CORE_RUN_CTRL_STALL_EN to build the stall counter.
// Without it, stall_count is tied to 0.
module core_run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 35,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_in,
  input  logic             retire_valid,
  output logic             core_rst_n,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
);

  // The budget is tracked by its own counter. The reported cycle_count can
  // saturate below MAX_CYCLES when CNT_W is narrow, so it cannot be used to
  // detect the end of the budget.
  localparam int BW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [7:0]       r_hold;
  logic [BW-1:0]    r_budget;
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_ins;
  logic             w_launch;

  assign w_launch = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_hold     <= '0;
      r_budget   <= '0;
      r_cyc      <= '0;
      r_ins      <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_launch) begin
            r_state  <= S_RESET;
            r_hold   <= '0;
            r_budget <= '0;
            r_cyc    <= '0;
            r_ins    <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            timeout  <= 1'b0;
          end
        end
        S_RESET: begin
          // The hold counter starts at 0 on the launch edge. The core is
          // released RST_CYCLES+1 edges after the start pulse was sampled.
          if (r_hold == 8'(RST_CYCLES)) begin
            r_state    <= S_RUN;
            core_rst_n <= 1'b1;
          end else begin
            r_hold <= r_hold + 8'd1;
          end
        end
        S_RUN: begin
          if (r_cyc != '1) r_cyc <= r_cyc + 1'b1;
          if (retire_valid && (r_ins != '1)) r_ins <= r_ins + 1'b1;
          r_budget <= r_budget + 1'b1;
          // If halt and budget exhaustion happen together, halt wins.
          if (halt_in || (r_budget == BW'(MAX_CYCLES - 1))) begin
            r_state    <= S_DONE;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            timeout    <= ~halt_in;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cycle_count = r_cyc;
  assign instr_count = r_ins;

`ifdef CORE_RUN_CTRL_STALL_EN
  logic [CNT_W-1:0] r_stall;

  always_ff @(posedge clk) begin
    if (rst || w_launch)
      r_stall <= '0;
    else if ((r_state == S_RUN) && !retire_valid && (r_stall != '1))
      r_stall <= r_stall + 1'b1;
  end

  assign stall_count = r_stall;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl. It drives two instances that share clk, rst,
// halt_in and retire_valid:
//   d0  uses the default parameters
//   d1  uses CNT_W=4 and MAX_CYCLES=40 to exercise saturation
// Each instance has its own start input. A reference model follows each run
// with plain integers: edges since start, RUN cycles and retires. Expected
// outputs are derived from those integers on every cycle.
module tb_core_run_ctrl;
  localparam int RSTC = 2;

  logic clk = 1'b0;
  logic rst, start0, start1, halt_in, retire_valid;
  logic rn0, busy0, done0, to0, rn1, busy1, done1, to1;
  logic [31:0] cyc0, ins0, stl0;
  logic [3:0]  cyc1, ins1, stl1;

  int nasserts = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  core_run_ctrl #(.RST_CYCLES(RSTC), .MAX_CYCLES(35), .CNT_W(32)) d0 (
    .clk(clk), .rst(rst), .start(start0), .halt_in(halt_in), .retire_valid(retire_valid),
    .core_rst_n(rn0), .busy(busy0), .done(done0), .timeout(to0),
    .cycle_count(cyc0), .instr_count(ins0), .stall_count(stl0));

  core_run_ctrl #(.RST_CYCLES(RSTC), .MAX_CYCLES(40), .CNT_W(4)) d1 (
    .clk(clk), .rst(rst), .start(start1), .halt_in(halt_in), .retire_valid(retire_valid),
    .core_rst_n(rn1), .busy(busy1), .done(done1), .timeout(to1),
    .cycle_count(cyc1), .instr_count(ins1), .stall_count(stl1));

  // Reference model, one slot per instance.
  int maxc[2] = '{35, 40};
  int wid[2]  = '{32, 4};
  int m_since[2], m_runs[2], m_ins[2], m_stl[2];
  bit m_busy[2], m_done[2], m_to[2];

  function automatic logic [63:0] sat(int v, int w);
    longint lim = (64'sd1 <<< w) - 1;
    return (longint'(v) > lim) ? 64'(lim) : 64'(v);
  endfunction

  task automatic model_step(int i, bit st);
    if (rst) begin
      m_busy[i] = 0; m_done[i] = 0; m_to[i] = 0;
      m_since[i] = 0; m_runs[i] = 0; m_ins[i] = 0; m_stl[i] = 0;
    end else if (!m_busy[i] && st) begin
      m_busy[i] = 1; m_done[i] = 0; m_to[i] = 0;
      m_since[i] = 0; m_runs[i] = 0; m_ins[i] = 0; m_stl[i] = 0;
    end else if (m_busy[i]) begin
      // An edge counts as a RUN cycle once the core has been released.
      if (m_since[i] > RSTC) begin
        m_runs[i]++;
        if (retire_valid) m_ins[i]++; else m_stl[i]++;
        if (halt_in) begin
          m_busy[i] = 0; m_done[i] = 1; m_to[i] = 0;
        end else if (m_runs[i] == maxc[i]) begin
          m_busy[i] = 0; m_done[i] = 1; m_to[i] = 1;
        end
      end
      m_since[i]++;
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nasserts++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_stall(int i);
`ifdef CORE_RUN_CTRL_STALL_EN
    return sat(m_stl[i], wid[i]);
`else
    return 64'd0;
`endif
  endfunction

  task automatic check_all();
    chk("d0.core_rst_n", 64'(rn0), 64'(m_busy[0] && m_since[0] > RSTC));
    chk("d0.busy", 64'(busy0), 64'(m_busy[0]));
    chk("d0.done", 64'(done0), 64'(m_done[0]));
    chk("d0.timeout", 64'(to0), 64'(m_to[0]));
    chk("d0.cycle_count", 64'(cyc0), sat(m_runs[0], 32));
    chk("d0.instr_count", 64'(ins0), sat(m_ins[0], 32));
    chk("d0.stall_count", 64'(stl0), exp_stall(0));
    chk("d1.core_rst_n", 64'(rn1), 64'(m_busy[1] && m_since[1] > RSTC));
    chk("d1.busy", 64'(busy1), 64'(m_busy[1]));
    chk("d1.done", 64'(done1), 64'(m_done[1]));
    chk("d1.timeout", 64'(to1), 64'(m_to[1]));
    chk("d1.cycle_count", 64'(cyc1), sat(m_runs[1], 4));
    chk("d1.instr_count", 64'(ins1), sat(m_ins[1], 4));
    chk("d1.stall_count", 64'(stl1), exp_stall(1));
  endtask

  // One clock: the DUT and the model both consume the current inputs. The
  // outputs are then checked 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_step(0, start0);
    model_step(1, start1);
    #1;
    check_all();
  endtask

  task automatic idle_in();
    rst = 0; start0 = 0; start1 = 0; halt_in = 0; retire_valid = 0;
  endtask

  task automatic launch0();
    start0 = 1; tick(); start0 = 0;
    // Inputs are ignored while the core is held in reset.
    for (int k = 0; k < RSTC + 1; k++) begin
      halt_in = 1'($urandom); retire_valid = 1'($urandom); tick();
    end
  endtask

  initial begin
    idle_in(); rst = 1;
    tick(); tick();
    rst = 0;
    for (int k = 0; k < 10; k++) tick();
    chk("idle.core_rst_n", 64'(rn0), 64'd0);
    chk("idle.cycle_count", 64'(cyc0), 64'd0);

    // Timeout run: retire on every cycle, no halt.
    start0 = 1; tick(); start0 = 0;
    tick(); tick();
    chk("lat.pre_release", 64'(rn0), 64'd0);
    tick();
    chk("lat.release", 64'(rn0), 64'd1);
    retire_valid = 1;
    for (int k = 0; k < 40; k++) tick();
    chk("to.done", 64'(done0), 64'd1);
    chk("to.timeout", 64'(to0), 64'd1);
    chk("to.cycle_count", 64'(cyc0), 64'd35);
    chk("to.instr_count", 64'(ins0), 64'd35);

    // Halt run: retire on even RUN cycles, halt on RUN cycle 10.
    launch0();
    for (int k = 1; k <= 10; k++) begin
      retire_valid = (k % 2 == 0); halt_in = (k == 10); tick();
    end
    for (int k = 0; k < 4; k++) begin
      halt_in = 1'($urandom); retire_valid = 1'($urandom); tick();
    end
    chk("halt.timeout", 64'(to0), 64'd0);
    chk("halt.cycle_count", 64'(cyc0), 64'd10);
    chk("halt.instr_count", 64'(ins0), 64'd5);
`ifdef CORE_RUN_CTRL_STALL_EN
    chk("halt.stall_count", 64'(stl0), 64'd5);
`endif

    // Halt on the last budget cycle: halt wins.
    launch0();
    for (int k = 1; k <= 35; k++) begin
      retire_valid = 1'($urandom); halt_in = (k == 35); tick();
    end
    halt_in = 0; tick();
    chk("coin.timeout", 64'(to0), 64'd0);
    chk("coin.cycle_count", 64'(cyc0), 64'd35);

    // Reset during RUN cycle 7.
    launch0();
    halt_in = 0;
    for (int k = 1; k <= 6; k++) begin retire_valid = 1'($urandom); tick(); end
    rst = 1; tick(); rst = 0;
    chk("mrst.core_rst_n", 64'(rn0), 64'd0);
    chk("mrst.cycle_count", 64'(cyc0), 64'd0);
    chk("mrst.busy", 64'(busy0), 64'd0);
    tick();

    // A start pulse during RUN is ignored. A start from DONE restarts the run.
    launch0();
    for (int k = 1; k <= 40; k++) begin
      retire_valid = 1'($urandom); start0 = (k == 5); tick();
    end
    start0 = 0;
    chk("rerun.done", 64'(done0), 64'd1);
    launch0();
    chk("rerun.busy", 64'(busy0), 64'd1);
    for (int k = 0; k < 40; k++) begin retire_valid = 1'($urandom); tick(); end

    // Random traffic: starts, halts, retires and occasional resets.
    for (int k = 0; k < 600; k++) begin
      start0       = ($urandom_range(14) == 0);
      halt_in      = ($urandom_range(11) == 0);
      retire_valid = 1'($urandom);
      rst          = ($urandom_range(99) == 0);
      tick();
    end
    idle_in();
    tick();

    // Saturation on the narrow instance.
    start1 = 1; tick(); start1 = 0;
    retire_valid = 1;
    for (int k = 0; k < 45; k++) tick();
    chk("sat.cycle_count", 64'(cyc1), 64'd15);
    chk("sat.instr_count", 64'(ins1), 64'd15);
    chk("sat.timeout", 64'(to1), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
    $finish;
  end
endmodule
